// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage.
// Queue entries pair each instruction word with its PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_RUN,
    FS_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// IMem read port plus decode valid/ready handshake.
// The master side is the fetch unit.
interface fetch_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetched entries.
// Pointers carry one extra wrap bit to tell full from empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(QDEPTH);

  fetch_entry_t   mem [QDEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW])
              && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++)
        mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wptr[AW-1:0]] <= push_entry;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, IMem addressing, fetch queue and sticky fault.
// IMem is word-indexed and 1-based, hence the +1 on the address.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 10240,
  parameter int          QDEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  fetch_if.master     bus,
  output logic        fault,
  output logic [31:0] fault_pc
);

  fetch_state_e state;
  fetch_state_e state_nx;
  logic [31:0]  pc;
  logic         pc_ok;
  logic         tgt_ok;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t head;
  fetch_entry_t entry;

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00)
        && ((a >> 2) < 32'(IMEM_WORDS));
  endfunction

  assign pc_ok  = legal(pc);
  assign tgt_ok = legal(redirect_pc);
  assign pop    = bus.inst_valid && bus.inst_ready;
  assign entry  = '{pc: pc, inst: bus.imem_data};

  assign bus.imem_addr  = (pc >> 2) + 32'd1;
  assign bus.inst_valid = !empty;
  assign bus.inst_data  = head.inst;
  assign bus.inst_pc    = head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FS_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (redirect_valid) begin
      if (!tgt_ok)       state_nx = FS_HALT;
      else if (fetch_en) state_nx = FS_RUN;
      else               state_nx = FS_IDLE;
    end else begin
      unique case (state)
        FS_IDLE: if (fetch_en) state_nx = FS_RUN;
        FS_RUN: begin
          if (!pc_ok)         state_nx = FS_HALT;
          else if (!fetch_en) state_nx = FS_IDLE;
        end
        FS_HALT: state_nx = FS_HALT;
        default: state_nx = FS_IDLE;
      endcase
    end
  end

  always_comb begin
    push = 1'b0;
    if (state == FS_RUN && !redirect_valid)
      push = pc_ok && (!full || pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (push)           pc <= pc + PC_STEP;
  end

  // A bad target is reported as the PC it would have become.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      fault <= !tgt_ok;
      if (!tgt_ok) fault_pc <= redirect_pc;
    end else if (state == FS_RUN && !pc_ok) begin
      fault    <= 1'b1;
      fault_pc <= pc;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .full       (full),
    .empty      (empty),
    .head       (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model.
// Model advances on each edge; outputs compared on falling edges.
module tb_fetch_unit;

  localparam int WORDS = 10240;
  localparam int QD    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready = 1'b0;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int failures = 0;

  fetch_if bus ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign bus.imem_data  = mem_word(bus.imem_addr);
  assign bus.inst_ready = ready;

  fetch_unit #(
    .RESET_PC   (32'h0),
    .IMEM_WORDS (WORDS),
    .QDEPTH     (QD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus.master),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: the fetch stream as a queue of PCs.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic        m_armed;
  logic        m_fault;
  logic [31:0] m_fpc;
  logic [31:0] last_pc = '0;

  function automatic logic ok(input logic [31:0] a);
    return a[1:0] == 2'b00 && (a >> 2) < WORDS;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_pc = 32'h0;
      m_armed = 1'b0;
      m_fault = 1'b0;
      m_fpc = '0;
    end else begin
      if (redirect_valid) begin
        m_q.delete();
        m_pc = redirect_pc;
        m_fault = !ok(redirect_pc);
        if (m_fault) m_fpc = redirect_pc;
      end else begin
        if (m_q.size() != 0 && ready)
          void'(m_q.pop_front());
        if (!m_fault && m_armed) begin
          if (!ok(m_pc)) begin
            m_fault = 1'b1;
            m_fpc = m_pc;
          end else if (m_q.size() < QD) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
          end
        end
      end
      m_armed = fetch_en;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("addr", bus.imem_addr, (m_pc >> 2) + 32'd1);
      chk("valid", 32'(bus.inst_valid),
          32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("pc", bus.inst_pc, m_q[0]);
        chk("data", bus.inst_data,
            mem_word((m_q[0] >> 2) + 32'd1));
      end
      chk("fault", 32'(fault), 32'(m_fault));
      if (m_fault) chk("fpc", fault_pc, m_fpc);
      if (bus.inst_valid && ready) last_pc = bus.inst_pc;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    ready = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_pc", bus.inst_pc, 32'h0);
    chk("rst_data", bus.inst_data, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_fpc", fault_pc, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h1);

    // 1: streaming fetch
    do_reset();
    fetch_en = 1'b1;
    ready = 1'b1;
    cyc();
    chk("t1_addr0", bus.imem_addr, 32'h1);
    chk("t1_v0", 32'(bus.inst_valid), 32'h0);
    cyc();
    chk("t1_pc0", bus.inst_pc, 32'h0);
    chk("t1_d0", bus.inst_data, 32'hBEEE_0001);
    chk("t1_addr1", bus.imem_addr, 32'h2);
    cyc();
    chk("t1_pc1", bus.inst_pc, 32'h4);
    chk("t1_addr2", bus.imem_addr, 32'h3);
    cyc();
    chk("t1_pc2", bus.inst_pc, 32'h8);
    chk("t1_d2", bus.inst_data, 32'hBEEC_0003);

    // 2: full queue stalls pc
    do_reset();
    fetch_en = 1'b1;
    cyc(6);
    chk("t2_addr", bus.imem_addr, 32'h5);
    chk("t2_head", bus.inst_pc, 32'h0);
    cyc();
    chk("t2_hold", bus.imem_addr, 32'h5);
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("t2_drain", bus.inst_pc, 32'(4 * i));
    end

    // 3: redirect flush
    do_reset();
    fetch_en = 1'b1;
    cyc(4);
    redir(32'h100);
    chk("t3_flush", 32'(bus.inst_valid), 32'h0);
    chk("t3_addr", bus.imem_addr, 32'h41);
    cyc();
    chk("t3_pc", bus.inst_pc, 32'h100);
    chk("t3_v", 32'(bus.inst_valid), 32'h1);

    // 4: misaligned target then recovery
    ready = 1'b1;
    redir(32'h102);
    chk("t4_fault", 32'(fault), 32'h1);
    chk("t4_fpc", fault_pc, 32'h102);
    cyc(3);
    chk("t4_nopush", 32'(bus.inst_valid), 32'h0);
    redir(32'h200);
    chk("t4_clear", 32'(fault), 32'h0);
    cyc();
    chk("t4_pc", bus.inst_pc, 32'h200);

    // 5: run off the end of IMem
    redir(32'h9FF0);
    for (int i = 0; i < 20 && !fault; i++) cyc();
    cyc(3);
    chk("t5_fault", 32'(fault), 32'h1);
    chk("t5_fpc", fault_pc, 32'hA000);
    chk("t5_v", 32'(bus.inst_valid), 32'h0);
    chk("t5_last", last_pc, 32'h9FFC);

    // 6: async reset with a full queue
    do_reset();
    fetch_en = 1'b1;
    cyc(8);
    chk("t6_full", 32'(bus.inst_valid), 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async", 32'(bus.inst_valid), 32'h0);
    chk("t6_pc0", bus.inst_pc, 32'h0);
    cyc(2);
    rst_n = 1'b1;
    ready = 1'b1;
    cyc(2);
    chk("t6_first", bus.inst_pc, 32'h0);
    chk("t6_fv", 32'(bus.inst_valid), 32'h1);
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
